regfile_sb: RTL

//  Parametrised GPR file for the 5-stage pipeline: NRP read ports, EX>ME>WB forwarding, load-use stall.

---
 rtl/regfile_sb_pkg.sv | 21 ++
 rtl/regfile_sb_if.sv | 68 ++++++
 rtl/regfile_sb_scoreboard.sv | 54 +++++
 rtl/regfile_sb.sv | 125 ++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the regfile_sb slice (register file, forwarding, scoreboard).
// Optional feature macro used across the slice: RF_LINK_PORT_EN.
package regfile_sb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;
    localparam int REG_LINK = 31;

    // Where a read port takes its operand from, in descending priority after the zero rule.
    typedef enum logic [2:0] {
        SRC_REG,
        SRC_ZERO,
        SRC_LINK,
        SRC_EX,
        SRC_ME,
        SRC_LW,
        SRC_WB
    } fwd_src_e;

endpackage

// File: rtl/regfile_sb_if.sv
// ID-stage register file bus: read ports, issue info, pipeline results and write-back ports.
// RF_LINK_PORT_EN adds the dedicated link-register write port (ra_we/ra_wd).
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = $clog2(NREG_DEF),
    parameter int NRP  = 2
);

    logic [NRP*AW-1:0]   r_addr;
    logic [NRP-1:0]      r_used;
    logic [NRP*XLEN-1:0] r_data;
    logic                stall;

    logic                iss_we;
    logic                iss_long;
    logic [AW-1:0]       iss_wa;

    logic                ex_we;
    logic                ex_ld;
    logic [AW-1:0]       ex_wa;
    logic [XLEN-1:0]     ex_wd;

    logic                me_we;
    logic [AW-1:0]       me_wa;
    logic [XLEN-1:0]     me_wd;

    logic                wb_we;
    logic [AW-1:0]       wb_wa;
    logic [XLEN-1:0]     wb_wd;

    logic                lw_we;
    logic [AW-1:0]       lw_wa;
    logic [XLEN-1:0]     lw_wd;

`ifdef RF_LINK_PORT_EN
    logic                ra_we;
    logic [XLEN-1:0]     ra_wd;
`endif

    modport master (
        output r_addr, r_used,
        output iss_we, iss_long, iss_wa,
        output ex_we, ex_ld, ex_wa, ex_wd,
        output me_we, me_wa, me_wd,
        output wb_we, wb_wa, wb_wd,
        output lw_we, lw_wa, lw_wd,
`ifdef RF_LINK_PORT_EN
        output ra_we, ra_wd,
`endif
        input  r_data, stall
    );

    modport slave (
        input  r_addr, r_used,
        input  iss_we, iss_long, iss_wa,
        input  ex_we, ex_ld, ex_wa, ex_wd,
        input  me_we, me_wa, me_wd,
        input  wb_we, wb_wa, wb_wd,
        input  lw_we, lw_wa, lw_wd,
`ifdef RF_LINK_PORT_EN
        input  ra_we, ra_wd,
`endif
        output r_data, stall
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Per-register pending bits for long-latency results returning on the lw port,
// plus the RAW and WAW stall terms they produce.
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int NRP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRP*AW-1:0] r_addr,
    input  logic [NRP-1:0]    r_used,
    input  logic              iss_we,
    input  logic              iss_long,
    input  logic [AW-1:0]     iss_wa,
    input  logic              lw_we,
    input  logic [AW-1:0]     lw_wa,
    output logic              stall_raw,
    output logic              stall_waw
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NRP-1:0]  raw_hit;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_we && iss_long && iss_wa != AW'(REG_ZERO))
            set_vec[iss_wa] = 1'b1;
        if (lw_we)
            clr_vec[lw_wa] = 1'b1;
    end

    // Set is OR-ed after the clear so a new issue keeps ownership of the register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pending <= '0;
        else
            pending <= set_vec | (pending & ~clr_vec);
    end

    for (genvar p = 0; p < NRP; p++) begin : g_raw
        logic [AW-1:0] a;
        assign a          = r_addr[p*AW +: AW];
        assign raw_hit[p] = r_used[p] && pending[a] && !(lw_we && lw_wa == a);
    end

    assign stall_raw = |raw_hit;
    assign stall_waw = iss_we && pending[iss_wa] && !(lw_we && lw_wa == iss_wa);

endmodule

// File: rtl/regfile_sb.sv
// GPR file for the 5-stage pipeline: NRP forwarded read ports, load-use and scoreboard stalls.
// Optional RF_LINK_PORT_EN: dedicated link-register write port owning regs[LINK_REG].
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int AW       = $clog2(NREG),
    parameter int NRP      = 2,
    parameter int LINK_REG = REG_LINK
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave rf
);

    logic [XLEN-1:0]          regs [NREG];
    logic [NRP-1:0][XLEN-1:0] rd;
    logic [NRP-1:0]           lu_hit;
    logic                     stall_raw;
    logic                     stall_waw;
    logic                     wb_ok;
    logic                     lw_ok;

`ifdef RF_LINK_PORT_EN
    localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
    assign wb_ok = rf.wb_wa != AW'(REG_ZERO) && rf.wb_wa != LINK_A;
    assign lw_ok = rf.lw_wa != AW'(REG_ZERO) && rf.lw_wa != LINK_A;
`else
    assign wb_ok = rf.wb_wa != AW'(REG_ZERO);
    assign lw_ok = rf.lw_wa != AW'(REG_ZERO);
`endif

    // lw is written before wb so that wb wins a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++)
                regs[AW'(i)] <= '0;
        end else begin
            if (rf.lw_we && lw_ok)
                regs[rf.lw_wa] <= rf.lw_wd;
            if (rf.wb_we && wb_ok)
                regs[rf.wb_wa] <= rf.wb_wd;
`ifdef RF_LINK_PORT_EN
            if (rf.ra_we)
                regs[LINK_A] <= rf.ra_wd;
`endif
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        fwd_src_e        src;

        assign a = rf.r_addr[p*AW +: AW];

        always_comb begin
            src = SRC_REG;
            if (a == AW'(REG_ZERO))
                src = SRC_ZERO;
`ifdef RF_LINK_PORT_EN
            // Only the link port can change LINK_REG, so pipeline results are never forwarded to it.
            else if (a == LINK_A)
                src = rf.ra_we ? SRC_LINK : SRC_REG;
`endif
            else if (rf.ex_we && rf.ex_wa == a)
                src = SRC_EX;
            else if (rf.me_we && rf.me_wa == a)
                src = SRC_ME;
            else if (rf.lw_we && rf.lw_wa == a)
                src = SRC_LW;
            else if (rf.wb_we && rf.wb_wa == a)
                src = SRC_WB;
        end

        always_comb begin
            case (src)
                SRC_ZERO: d = '0;
`ifdef RF_LINK_PORT_EN
                SRC_LINK: d = rf.ra_wd;
`endif
                SRC_EX:   d = rf.ex_wd;
                SRC_ME:   d = rf.me_wd;
                SRC_LW:   d = rf.lw_wd;
                SRC_WB:   d = rf.wb_wd;
                default:  d = regs[a];
            endcase
        end

        assign rd[p]     = d;
        assign lu_hit[p] = rf.r_used[p] && rf.ex_we && rf.ex_ld
                           && a != AW'(REG_ZERO) && rf.ex_wa == a;
    end

    assign rf.r_data = rd;

    regfile_sb_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .NRP  (NRP)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .r_addr    (rf.r_addr),
        .r_used    (rf.r_used),
        .iss_we    (rf.iss_we),
        .iss_long  (rf.iss_long),
        .iss_wa    (rf.iss_wa),
        .lw_we     (rf.lw_we),
        .lw_wa     (rf.lw_wa),
        .stall_raw (stall_raw),
        .stall_waw (stall_waw)
    );

    assign rf.stall = (|lu_hit) || stall_raw || stall_waw;

    a_params: assert property (@(posedge clk)
        (LINK_REG < NREG) && (NREG == (1 << AW)) && (NREG >= 2));

    // A wb/lw collision means the caller ignored the WAW stall.
    a_no_collision: assert property (@(posedge clk) disable iff (!rst)
        !(rf.wb_we && rf.lw_we && rf.wb_wa == rf.lw_wa && rf.wb_wa != AW'(REG_ZERO)));

endmodule
